// File: rtl/sensor_sequencer.sv
// Pixel-sensor frame sequencer: erase, exposure, ramp conversion and a
// row-by-row readout with a valid/ready handshake towards the row buffer.
module sensor_sequencer #(
  parameter int ROWS         = 2,
  parameter int PIXEL_BITS   = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 16,
  localparam int RI_W        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [EXP_W-1:0]      expose_cycles,
  input  logic                  abort,
  output logic                  p_erase,
  output logic                  p_expose,
  output logic                  p_expose_clk,
  output logic [PIXEL_BITS-1:0] p_dRamp,
  output logic [ROWS-1:0]       p_row_select,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [RI_W-1:0]       row_index,
  output logic                  busy,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  // Row handshake: a row transfers on every rising edge where row_valid and
  // row_ready are both high; row_valid depends only on registered state.

  localparam int EW    = $clog2(ERASE_CYCLES + 1);
  localparam int CNT_W = (EXP_W > EW) ? EXP_W : EW;
  localparam int RW    = PIXEL_BITS + 1;
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [RI_W-1:0]  ROW_LAST   = RI_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READOUT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EXP_W-1:0]    exp_len_q, exp_len_d;
  logic [RW-1:0]       ramp_q, ramp_d;
  logic [RI_W-1:0]     row_q, row_d;
  logic [CNT_W-1:0]    exp_last;
  logic [RW-1:0]       ramp_inc;

  logic                p_erase_q, p_erase_d;
  logic                p_expose_q, p_expose_d;
  logic                p_expose_clk_q, p_expose_clk_d;
  logic [PIXEL_BITS-1:0] p_dramp_q, p_dramp_d;
  logic [ROWS-1:0]     p_row_select_q, p_row_select_d;
  logic                row_valid_q, row_valid_d;
  logic [RI_W-1:0]     row_index_q, row_index_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  assign exp_last = CNT_W'(exp_len_q) - CNT_W'(1);
  assign ramp_inc = ramp_q + RW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_len_d = exp_len_q;
    ramp_d    = ramp_q;
    row_d     = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ERASE;
          cnt_d     = '0;
          exp_len_d = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
        end
      end
      S_ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXPOSE: begin
        if (cnt_q == exp_last) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
          ramp_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CONVERT: begin
        // The extra ramp bit flags the terminal step without wrapping to 0.
        if (ramp_inc[PIXEL_BITS]) begin
          state_d = S_READOUT;
          ramp_d  = '0;
          row_d   = '0;
        end else begin
          ramp_d = ramp_inc;
        end
      end
      S_READOUT: begin
        if (row_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + RI_W'(1);
          end
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d   = S_ERASE;
          cnt_d     = '0;
          exp_len_d = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ramp_d  = '0;
      row_d   = '0;
    end
  end

  // Outputs are registered decodes of the next state so they line up with it.
  always_comb begin
    p_erase_d      = (state_d == S_ERASE);
    p_expose_d     = (state_d == S_EXPOSE);
    p_expose_clk_d = 1'b0;
    if (state_d == S_EXPOSE)
      p_expose_clk_d = (state_q == S_EXPOSE) ? ~p_expose_clk_q : 1'b1;
    p_dramp_d      = (state_d == S_CONVERT) ? ramp_d[PIXEL_BITS-1:0] : '0;
    p_row_select_d = (state_d == S_READOUT) ? (ROWS'(1) << row_d) : '0;
    row_valid_d    = (state_d == S_READOUT);
    row_index_d    = (state_d == S_READOUT) ? row_d : '0;
    busy_d         = (state_d != S_IDLE);
    frame_done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      exp_len_q      <= '0;
      ramp_q         <= '0;
      row_q          <= '0;
      p_erase_q      <= 1'b0;
      p_expose_q     <= 1'b0;
      p_expose_clk_q <= 1'b0;
      p_dramp_q      <= '0;
      p_row_select_q <= '0;
      row_valid_q    <= 1'b0;
      row_index_q    <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      exp_len_q      <= exp_len_d;
      ramp_q         <= ramp_d;
      row_q          <= row_d;
      p_erase_q      <= p_erase_d;
      p_expose_q     <= p_expose_d;
      p_expose_clk_q <= p_expose_clk_d;
      p_dramp_q      <= p_dramp_d;
      p_row_select_q <= p_row_select_d;
      row_valid_q    <= row_valid_d;
      row_index_q    <= row_index_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign p_erase      = p_erase_q;
  assign p_expose     = p_expose_q;
  assign p_expose_clk = p_expose_clk_q;
  assign p_dRamp      = p_dramp_q;
  assign p_row_select = p_row_select_q;
  assign row_valid    = row_valid_q;
  assign row_index    = row_index_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/sensor_sequencer.md
# sensor_sequencer

Parametrised next-generation pixel-sensor frame sequencer. It drives the pixel array through erase, exposure, ramp conversion and row-by-row readout. Compared with the fixed sensor state machine, it adds run-time exposure length, single-shot or continuous frame modes, abort, and a valid/ready readout handshake so a downstream row buffer can stall readout. It sits between the top-level controller and the pixel array / readout path.

## Interface
Parameters:
- ROWS, default 2: pixel array height; width of p_row_select.
- PIXEL_BITS, default 8: ramp / ADC resolution; width of p_dRamp.
- ERASE_CYCLES, default 5: fixed erase length in clk cycles, ≥1.
- EXP_W, default 16: width of expose_cycles.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- reset, in, 1: asynchronous, active-high; all state returns to IDLE.
- start, in, 1: pulse that begins a frame. Ignored while busy=1.
- continuous, in, 1: sampled in DONE. When 1, the next frame starts immediately.
- expose_cycles, in, EXP_W: exposure length. Sampled at each frame start; 0 is treated as 1.
- abort, in, 1: synchronous abort, effective in any non-IDLE state.
- p_erase, out, 1: high during ERASE.
- p_expose, out, 1: high during EXPOSE.
- p_expose_clk, out, 1: registered toggle, active only during EXPOSE.
- p_dRamp, out, PIXEL_BITS: ramp value during CONVERT.
- p_row_select, out, ROWS: one-hot row select during READOUT, otherwise 0.
- row_valid, out, 1: current row is selected and may be read.
- row_ready, in, 1: downstream accepts the current row.
- row_index, out, max(1,$clog2(ROWS)): index of the selected row.
- busy, out, 1: high in every state except IDLE.
- frame_done, out, 1: one-cycle pulse at the end of a completed frame.

## Operation
- States and transitions:
  - IDLE → ERASE → EXPOSE → CONVERT → READOUT → DONE.
  - DONE → ERASE if continuous=1, else DONE → IDLE.
- Frame start: start=1 in IDLE, or DONE with continuous=1.
  - expose_cycles is latched into an internal register at frame start.
  - A 0 value is loaded as 1.
  - Changes to expose_cycles mid-frame have no effect.
- ERASE: p_erase=1 for exactly ERASE_CYCLES cycles.
- EXPOSE: p_expose=1 for exactly the latched N cycles.
  - p_expose_clk is 1 on the first EXPOSE cycle and inverts every cycle after that.
  - p_expose_clk is 0 in all other states.
- CONVERT: p_dRamp = 0, 1, …, 2^PIXEL_BITS−1, one step per cycle, 2^PIXEL_BITS cycles in total.
  - p_dRamp is held at 0 outside CONVERT.
  - The ramp counter is PIXEL_BITS+1 wide internally so the terminal count is detectable without wrap.
- READOUT: rows are presented in order 0 → ROWS−1.
  - While presenting row r: p_row_select has only bit r set, row_index=r, row_valid=1.
  - A transfer occurs on any cycle with row_valid & row_ready. The next cycle presents row r+1.
  - While row_ready=0, the current row is held indefinitely.
  - After the transfer of row ROWS−1, the state moves to DONE.
- DONE: lasts one cycle with frame_done=1 and busy=1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; all outputs return to 0.
  - No frame_done is produced.
  - abort takes priority over every other transition, including the row handshake.
  - abort in IDLE has no effect.
- Simultaneous events:
  - start together with abort in IDLE: the frame starts.
  - start while busy: ignored, not queued.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset may assert mid-frame and takes effect immediately (asynchronous).
- All outputs are registered (state-decoded from registers). No combinational path from row_ready to row_valid.
- start sampled high at edge T:
  - busy=1 and p_erase=1 from T+1.
  - EXPOSE begins at T+1+ERASE_CYCLES.
- Frame length with row_ready held at 1: ERASE_CYCLES + N + 2^PIXEL_BITS + ROWS + 1 cycles, from the first busy cycle through the frame_done cycle.
- Continuous mode: p_erase of the next frame is asserted in the cycle directly after frame_done. There is no IDLE gap.
- Each cycle with row_ready=0 during READOUT lengthens the frame by one cycle.

## Test plan
All scenarios use the default parameters.
- Single shot, expose_cycles=10, row_ready=1, continuous=0:
  - p_erase high for 5 cycles, p_expose for 10, ramp 0..255 over 256 cycles.
  - p_row_select 01 then 10.
  - frame_done pulses once, 274 cycles after busy rises; busy falls the next cycle.
- Backpressure: row_ready=0 for 3 cycles on row 0, then 1.
  - p_row_select=01 and row_index=0 are held for 4 cycles.
  - Row 1 follows, and the frame is 3 cycles longer than the single-shot case.
- Exposure boundary: expose_cycles=0 gives p_expose high for exactly 1 cycle.
  - Changing expose_cycles to 50 during ERASE does not change the exposure length.
- Continuous: continuous=1, start once.
  - p_erase rises the cycle after each frame_done.
  - A start pulse during busy causes no change.
  - Clearing continuous before the second DONE makes the sequencer return to IDLE after 2 frames.
- Abort with p_dRamp=100 in CONVERT:
  - Next cycle: IDLE, all outputs 0, no frame_done.
  - A following start runs a full normal frame.
- Async reset asserted mid-EXPOSE:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the sequencer stays idle until start.
